// File: rtl/bch_31_deserializer.sv
// Serial-to-parallel framer: sof_i-aligned bit stream -> 31-bit received codewords for the BCH decoder.
// Latency: cw_valid_o rises on the clock edge that samples the 31st bit of a frame.
// Backpressure: one-entry output register; a word completing while it is full and unaccepted is dropped (overflow_o).
module bch_31_deserializer #(
    parameter int N         = 31,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_i,
    input  logic             bit_valid_i,
    input  logic             sof_i,
    output logic [N-1:0]     codeword_o,
    output logic             cw_valid_o,
    input  logic             cw_ready_i,
    output logic             frame_err_o,
    output logic             overflow_o,
    output logic [CNT_W-1:0] frame_count_o
);

    localparam int BW = $clog2(N + 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     sr_q, sr_d;
    logic [N-1:0]     sr_shift, sr_start;
    logic [N-1:0]     cw_q, cw_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             complete;

    // sr_start is the shift of an all-zero register: any partial word is discarded.
    always_comb begin
        if (MSB_FIRST) begin
            sr_shift = {sr_q[N-2:0], bit_i};
            sr_start = {{(N-1){1'b0}}, bit_i};
        end else begin
            sr_shift = {bit_i, sr_q[N-1:1]};
            sr_start = {bit_i, {(N-1){1'b0}}};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
        if (bit_valid_i) begin
            if (state_q == S_COLLECT) begin
                if (sof_i) begin
                    sr_d   = sr_start;
                    cnt_d  = BW'(1);
                    ferr_d = 1'b1;
                end else if (cnt_q == BW'(N - 1)) begin
                    complete = 1'b1;
                    sr_d     = '0;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                end else begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + BW'(1);
                end
            end else if (sof_i) begin
                sr_d    = sr_start;
                cnt_d   = BW'(1);
                state_d = S_COLLECT;
            end
        end
    end

    // A completing word may replace one that is being accepted in the same cycle.
    always_comb begin
        cw_d   = cw_q;
        vld_d  = vld_q;
        ovf_d  = ovf_q;
        fcnt_d = fcnt_q;
        if (complete && (!vld_q || cw_ready_i)) begin
            cw_d   = sr_shift;
            vld_d  = 1'b1;
            fcnt_d = fcnt_q + CNT_W'(1);
        end else if (complete) begin
            ovf_d = 1'b1;
        end else if (vld_q && cw_ready_i) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            cw_q    <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            cw_q    <= cw_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign codeword_o    = cw_q;
    assign cw_valid_o    = vld_q;
    assign frame_err_o   = ferr_q;
    assign overflow_o    = ovf_q;
    assign frame_count_o = fcnt_q;

endmodule

// File: tb/tb_bch_31_deserializer.sv
// Directed bench for bch_31_deserializer: an MSB-first instance and an LSB-first instance with a 4-bit frame counter.
// Both share the serial inputs; each scenario checks the instance whose bit order matches its stimulus.
module tb_bch_31_deserializer;

    logic        clk;
    logic        rst;
    logic        bit_i;
    logic        bit_valid_i;
    logic        sof_i;
    logic        cw_ready_i;

    logic [30:0] m_cw;
    logic        m_vld, m_ferr, m_ovf;
    logic [15:0] m_cnt;
    logic [30:0] l_cw;
    logic        l_vld, l_ferr, l_ovf;
    logic [3:0]  l_cnt;

    int n_vec = 0;
    int n_err = 0;

    bch_31_deserializer #(.N(31), .MSB_FIRST(1'b1), .CNT_W(16)) dut_m (
        .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i), .sof_i(sof_i),
        .codeword_o(m_cw), .cw_valid_o(m_vld), .cw_ready_i(cw_ready_i),
        .frame_err_o(m_ferr), .overflow_o(m_ovf), .frame_count_o(m_cnt)
    );

    bch_31_deserializer #(.N(31), .MSB_FIRST(1'b0), .CNT_W(4)) dut_l (
        .clk(clk), .rst(rst), .bit_i(bit_i), .bit_valid_i(bit_valid_i), .sof_i(sof_i),
        .codeword_o(l_cw), .cw_valid_o(l_vld), .cw_ready_i(cw_ready_i),
        .frame_err_o(l_ferr), .overflow_o(l_ovf), .frame_count_o(l_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are observed on the next falling edge.
    task automatic send_bit(input logic b, input logic s, input logic r);
        bit_i       = b;
        sof_i       = s;
        bit_valid_i = 1'b1;
        cw_ready_i  = r;
        @(negedge clk);
        bit_valid_i = 1'b0;
        sof_i       = 1'b0;
    endtask

    task automatic send_frame(input logic [30:0] w, input bit msb, input logic r_body, input logic r_last);
        for (int i = 0; i < 31; i++)
            send_bit(msb ? w[30-i] : w[i], i == 0, (i == 30) ? r_last : r_body);
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        bit_valid_i = 1'b0;
        sof_i       = 1'b0;
        bit_i       = 1'b0;
        cw_ready_i  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; bit_valid_i = 1'b0; sof_i = 1'b0; bit_i = 1'b0; cw_ready_i = 1'b0;
        #2;
        n_vec++; if (m_cw !== 31'h0) begin n_err++; $display("FAIL reset_cw got %h want 0", m_cw); end
        n_vec++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", m_vld); end
        n_vec++; if ({m_ferr, m_ovf} !== 2'b00) begin n_err++; $display("FAIL reset_flags got %b want 00", {m_ferr, m_ovf}); end
        n_vec++; if (m_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt got %h want 0", m_cnt); end
        n_vec++; if ({l_vld, l_cnt} !== 5'h0) begin n_err++; $display("FAIL reset_l got %h want 0", {l_vld, l_cnt}); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_msb_first();
        do_reset();
        send_frame(31'h5A5A_1234, 1'b1, 1'b1, 1'b1);
        n_vec++; if (m_vld !== 1'b1) begin n_err++; $display("FAIL msb_vld got %b want 1", m_vld); end
        n_vec++; if (m_cw !== 31'h5A5A_1234) begin n_err++; $display("FAIL msb_cw got %h want 5a5a1234", m_cw); end
        n_vec++; if (m_cnt !== 16'd1) begin n_err++; $display("FAIL msb_cnt got %0d want 1", m_cnt); end
        n_vec++; if ({m_ferr, m_ovf} !== 2'b00) begin n_err++; $display("FAIL msb_flags got %b want 00", {m_ferr, m_ovf}); end
        @(negedge clk);
        n_vec++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL msb_drain got %b want 0", m_vld); end
        n_vec++; if (m_cw !== 31'h5A5A_1234) begin n_err++; $display("FAIL msb_hold got %h want 5a5a1234", m_cw); end
    endtask

    task automatic test_lsb_first();
        do_reset();
        send_frame(31'h5A5A_1234, 1'b0, 1'b1, 1'b1);
        n_vec++; if (l_vld !== 1'b1) begin n_err++; $display("FAIL lsb_vld got %b want 1", l_vld); end
        n_vec++; if (l_cw !== 31'h5A5A_1234) begin n_err++; $display("FAIL lsb_cw got %h want 5a5a1234", l_cw); end
        n_vec++; if (l_cnt !== 4'd1) begin n_err++; $display("FAIL lsb_cnt got %0d want 1", l_cnt); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_frame(31'h1111_2222, 1'b1, 1'b0, 1'b0);
        n_vec++; if (m_cw !== 31'h1111_2222) begin n_err++; $display("FAIL ovf_first got %h want 11112222", m_cw); end
        n_vec++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", m_ovf); end
        send_frame(31'h3333_4444, 1'b1, 1'b0, 1'b0);
        n_vec++; if (m_cw !== 31'h1111_2222) begin n_err++; $display("FAIL ovf_held got %h want 11112222", m_cw); end
        n_vec++; if (m_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got %b want 1", m_ovf); end
        n_vec++; if (m_cnt !== 16'd1) begin n_err++; $display("FAIL ovf_cnt got %0d want 1", m_cnt); end
        n_vec++; if (m_vld !== 1'b1) begin n_err++; $display("FAIL ovf_vld got %b want 1", m_vld); end
        cw_ready_i = 1'b1;
        @(negedge clk);
        n_vec++; if (m_vld !== 1'b0) begin n_err++; $display("FAIL ovf_drain got %b want 0", m_vld); end
        n_vec++; if (m_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", m_ovf); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(31'h0ABC_DEF0, 1'b1, 1'b0, 1'b0);
        send_frame(31'h7654_3210, 1'b1, 1'b0, 1'b1);
        n_vec++; if (m_vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld got %b want 1", m_vld); end
        n_vec++; if (m_cw !== 31'h7654_3210) begin n_err++; $display("FAIL b2b_cw got %h want 76543210", m_cw); end
        n_vec++; if (m_cnt !== 16'd2) begin n_err++; $display("FAIL b2b_cnt got %0d want 2", m_cnt); end
        n_vec++; if (m_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", m_ovf); end
    endtask

    task automatic test_early_sof();
        logic [30:0] w;
        int pulses;
        w = 31'h0000_0001;
        pulses = 0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            send_bit(1'b1, i == 0, 1'b1);
            if (m_ferr === 1'b1) pulses++;
        end
        send_bit(w[30], 1'b1, 1'b1);
        n_vec++; if (m_ferr !== 1'b1) begin n_err++; $display("FAIL esof_pulse got %b want 1", m_ferr); end
        if (m_ferr === 1'b1) pulses++;
        for (int i = 1; i < 31; i++) begin
            send_bit(w[30-i], 1'b0, 1'b1);
            if (m_ferr === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 1) begin n_err++; $display("FAIL esof_count got %0d want 1", pulses); end
        n_vec++; if (m_cw !== 31'h0000_0001) begin n_err++; $display("FAIL esof_cw got %h want 00000001", m_cw); end
        n_vec++; if (m_cnt !== 16'd1) begin n_err++; $display("FAIL esof_cnt got %0d want 1", m_cnt); end
    endtask

    task automatic test_sof_on_31st();
        logic [30:0] w;
        w = 31'h4000_0003;
        do_reset();
        for (int i = 0; i < 30; i++) send_bit(1'b1, i == 0, 1'b1);
        send_bit(w[30], 1'b1, 1'b1);
        n_vec++; if (m_ferr !== 1'b1) begin n_err++; $display("FAIL s31_pulse got %b want 1", m_ferr); end
        n_vec++; if ({m_vld, m_cnt} !== 17'h0) begin n_err++; $display("FAIL s31_nodeliver got %h want 0", {m_vld, m_cnt}); end
        for (int i = 1; i < 31; i++) send_bit(w[30-i], 1'b0, 1'b1);
        n_vec++; if (m_cw !== 31'h4000_0003) begin n_err++; $display("FAIL s31_cw got %h want 40000003", m_cw); end
        n_vec++; if (m_cnt !== 16'd1) begin n_err++; $display("FAIL s31_cnt got %0d want 1", m_cnt); end
    endtask

    task automatic test_gaps();
        logic [30:0] w;
        w = 31'h3C3C_5AA5;
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b1);
        n_vec++; if ({m_vld, m_cnt} !== 17'h0) begin n_err++; $display("FAIL gap_idle got %h want 0", {m_vld, m_cnt}); end
        for (int i = 0; i < 31; i++) begin
            send_bit(w[30-i], i == 0, 1'b1);
            if (i % 7 == 3) repeat (3) @(negedge clk);
        end
        n_vec++; if (m_cw !== 31'h3C3C_5AA5) begin n_err++; $display("FAIL gap_cw got %h want 3c3c5aa5", m_cw); end
        n_vec++; if (m_cnt !== 16'd1) begin n_err++; $display("FAIL gap_cnt got %0d want 1", m_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(31'h0F0F_0F0F, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) send_bit(1'b1, i == 0, 1'b0);
        rst = 1'b0;
        #1;
        n_vec++; if ({m_vld, m_cw} !== 32'h0) begin n_err++; $display("FAIL rmid_out got %h want 0", {m_vld, m_cw}); end
        n_vec++; if ({m_ovf, m_cnt} !== 17'h0) begin n_err++; $display("FAIL rmid_cnt got %h want 0", {m_ovf, m_cnt}); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_frame(31'h2BCD_EF01, 1'b1, 1'b1, 1'b1);
        n_vec++; if (m_cw !== 31'h2BCD_EF01) begin n_err++; $display("FAIL rmid_cw got %h want 2bcdef01", m_cw); end
        n_vec++; if (m_cnt !== 16'd1) begin n_err++; $display("FAIL rmid_next got %0d want 1", m_cnt); end
    endtask

    task automatic test_count_wrap();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            send_frame(31'h1000_0000 + 31'(k), 1'b0, 1'b1, 1'b1);
            if (k == 14) begin
                n_vec++; if (l_cnt !== 4'hF) begin n_err++; $display("FAIL wrap_max got %0d want 15", l_cnt); end
            end
        end
        n_vec++; if (l_cnt !== 4'h0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", l_cnt); end
        n_vec++; if (l_cw !== 31'h1000_000F) begin n_err++; $display("FAIL wrap_cw got %h want 1000000f", l_cw); end
        n_vec++; if (m_cnt !== 16'd16) begin n_err++; $display("FAIL wrap_wide got %0d want 16", m_cnt); end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_overflow();
        test_back_to_back();
        test_early_sof();
        test_sof_on_31st();
        test_gaps();
        test_reset_mid();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bch_31_deserializer.md
Name: bch_31_deserializer

Overview:
- Upstream front-end for the BCH(31,21) decoder pipeline.
- Assembles a framed serial bit stream into 31-bit received codewords.
- Presents each codeword on a registered valid/ready output that drives the decoder's codeword input.
- Tracks framing errors, overflow and delivered-frame count for channel monitoring.

Parameters:
- N, 31, codeword length in bits; the only supported value is 31.
- MSB_FIRST, 1: 1 = first received bit lands in codeword_o[30]; 0 = first received bit lands in codeword_o[0].
- CNT_W, 16, width of frame_count_o.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bit_i  in  1  serial data bit.
- bit_valid_i  in  1  bit_i is valid this cycle.
- sof_i  in  1  start of frame; qualified by bit_valid_i; marks bit_i as codeword bit 0 in arrival order.
- codeword_o  out  31  assembled received codeword.
- cw_valid_o  out  1  codeword_o holds an undelivered word.
- cw_ready_i  in  1  consumer accepts codeword_o this cycle.
- frame_err_o  out  1  one-cycle pulse: frame aborted by an early sof_i.
- overflow_o  out  1  sticky: a completed word was dropped.
- frame_count_o  out  CNT_W  number of words loaded into the output register.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, bit counter=0, shift register=0.
  - codeword_o=0, cw_valid_o=0, frame_err_o=0, overflow_o=0, frame_count_o=0.
  - Reset asserted mid-frame discards the partial word and any pending output word.
- FSM, 2 states:
  - IDLE: bits without sof_i are ignored. On bit_valid_i & sof_i: capture the bit as bit 0, counter=1, go to COLLECT.
  - COLLECT, normal bit (bit_valid_i & ~sof_i): shift the bit in, counter++.
  - COLLECT, early sof_i (bit_valid_i & sof_i with counter<31): abort the partial word; this bit becomes bit 0; counter=1; frame_err_o=1 for one cycle; stay in COLLECT.
  - COLLECT, bit with counter==30 (31st bit, no sof_i): the frame is complete; go to IDLE and counter=0.
  - A completed frame needs no idle gap: sof_i on the very next cycle starts the next frame.
  - A sof_i coincident with what would be the 31st bit is treated as an early sof_i (abort plus frame_err_o pulse).
- Bit placement:
  - MSB_FIRST=1: sr <= {sr[29:0], bit_i}.
  - MSB_FIRST=0: sr <= {bit_i, sr[30:1]}.
  - The completed word includes the 31st bit in its final position.
- Output register (one entry):
  - Load condition: frame completes AND (cw_valid_o==0 OR (cw_valid_o & cw_ready_i)).
  - Load action: codeword_o=completed word, cw_valid_o=1, frame_count_o++.
  - Latency: cw_valid_o rises on the clock edge that samples the 31st bit, i.e. it is visible 1 cycle after that bit is presented.
  - Frame completes while cw_valid_o=1 & cw_ready_i=0: the new word is dropped; codeword_o is unchanged; overflow_o=1 (sticky until reset); frame_count_o is unchanged.
  - cw_valid_o & cw_ready_i with no completion: cw_valid_o=0. codeword_o keeps its last value.
  - While cw_valid_o=1, codeword_o is stable.
- frame_count_o wraps from 2^CNT_W-1 to 0.
- bit_valid_i=0: no state change. Partial frames persist indefinitely; there is no timeout.

Test Plan:
- Reset, then 31 bits with MSB_FIRST=1, sof_i on bit 0, pattern 31'h5A5A_1234, cw_ready_i=1 -> cw_valid_o=1 one cycle after the last bit; codeword_o=31'h5A5A_1234; frame_count_o=1; flags stay 0.
- Same frame with MSB_FIRST=0 and bits sent LSB-first -> codeword_o=31'h5A5A_1234.
- Two back-to-back frames with cw_ready_i=0 throughout -> first word held; second word dropped; overflow_o=1; frame_count_o=1. Then raise cw_ready_i -> cw_valid_o falls the next cycle; overflow_o stays 1.
- Frame completes in the same cycle as cw_ready_i=1 on a pending word -> new word loaded; cw_valid_o stays 1; frame_count_o=2; overflow_o=0.
- sof_i at bit 17, then 30 more bits of frame 31'h0000_0001 -> frame_err_o pulses once at bit 17; codeword_o=31'h0000_0001; frame_count_o=1.
- Reset asserted after 12 bits, released, then a full frame -> outputs 0 during reset; next word correct; frame_count_o=1. Also preload the count to 16'hFFFF via 65535 frames (or force) plus one more -> frame_count_o wraps to 0.
- End-to-end check: feed encoder codewords serially, with 0/1/2 bits flipped, through this block into the decoder -> decoder output equals the original codeword for up to 2 errors.
